// File: rtl/zuma_lut_cfg_loader_pkg.sv
// Shared types and default sizing for the LUT configuration loader.
// The checksum feature is controlled by the ZUMA_CFG_CHECKSUM_EN macro.
package zuma_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_e;

  localparam int ZUMA_LUT_K      = 6;
  localparam int ZUMA_CFG_GROUPS = 4;
  localparam int ZUMA_NUM_LUTS   = 8;

  // Group counter width; keeps at least one bit for a single-group build.
  function automatic int grp_w(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

endpackage

// File: rtl/zuma_lut_cfg_loader_if.sv
// Configuration stream and LUTRAM write bus between a config source and the loader.
interface zuma_lut_cfg_loader_if #(
  parameter int LUT_K      = zuma_cfg_pkg::ZUMA_LUT_K,
  parameter int NUM_LUTS   = zuma_cfg_pkg::ZUMA_NUM_LUTS,
  parameter int NUM_GROUPS = zuma_cfg_pkg::ZUMA_CFG_GROUPS
);
  logic                  cfg_start;
  logic [NUM_LUTS-1:0]   cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [LUT_K-1:0]      lut_a;
  logic [NUM_LUTS-1:0]   lut_d;
  logic [NUM_GROUPS-1:0] lut_we;
  logic                  busy;
  logic                  done;
  logic                  cfg_error;

  modport master (
    output cfg_start, cfg_data, cfg_valid,
    input  cfg_ready, lut_a, lut_d, lut_we, busy, done, cfg_error
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid,
    output cfg_ready, lut_a, lut_d, lut_we, busy, done, cfg_error
  );
endinterface

// File: rtl/zuma_lut_cfg_loader_addr_counter.sv
// Group/address walk counter for the loader; addr wraps into the next group.
module zuma_cfg_addr_counter
  import zuma_cfg_pkg::*;
#(
  parameter int LUT_K      = ZUMA_LUT_K,
  parameter int NUM_GROUPS = ZUMA_CFG_GROUPS,
  localparam int GW        = grp_w(NUM_GROUPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [GW-1:0]    grp_o,
  output logic [LUT_K-1:0] addr_o,
  output logic             last_o
);

  logic [GW-1:0]    grp_q;
  logic [LUT_K-1:0] addr_q;
  logic             addr_max;

  assign addr_max = &addr_q;
  assign last_o   = addr_max && (grp_q == GW'(NUM_GROUPS - 1));
  assign grp_o    = grp_q;
  assign addr_o   = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_q  <= '0;
      addr_q <= '0;
    end else if (clr_i) begin
      grp_q  <= '0;
      addr_q <= '0;
    end else if (inc_i) begin
      addr_q <= addr_q + 1'b1;
      if (addr_max) grp_q <= last_o ? '0 : grp_q + 1'b1;
    end
  end

endmodule

// File: rtl/zuma_lut_cfg_loader.sv
// Streams config words into LUTRAM writes, one group/address per accepted word.
// Optional trailing checksum word when ZUMA_CFG_CHECKSUM_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for cfg_start, not ready
// ST_LOAD  | accepting data words, one LUTRAM write each
// ST_CHECK | accepting the checksum word (checksum build only)
// ST_DONE  | sequence finished; done asserts and holds
module zuma_lut_cfg_loader
  import zuma_cfg_pkg::*;
#(
  parameter int LUT_K      = ZUMA_LUT_K,
  parameter int NUM_LUTS   = ZUMA_NUM_LUTS,
  parameter int NUM_GROUPS = ZUMA_CFG_GROUPS
) (
  input logic                  clk,
  input logic                  reset,
  zuma_lut_cfg_loader_if.slave bus
);

  localparam int GW = grp_w(NUM_GROUPS);

  cfg_state_e            state_q;
  logic                  cfg_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [LUT_K-1:0]      lut_a_q;
  logic [NUM_LUTS-1:0]   lut_d_q;
  logic [NUM_GROUPS-1:0] lut_we_q;

  logic [GW-1:0]         grp;
  logic [LUT_K-1:0]      addr;
  logic                  last;
  logic                  start_seq;
  logic                  wr_acc;
  logic [NUM_GROUPS-1:0] we_onehot;

  assign start_seq = bus.cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign wr_acc    = bus.cfg_valid && cfg_ready_q && (state_q == ST_LOAD);
  assign we_onehot = NUM_GROUPS'(1) << grp;

  zuma_cfg_addr_counter #(
    .LUT_K      (LUT_K),
    .NUM_GROUPS (NUM_GROUPS)
  ) u_addr_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start_seq),
    .inc_i  (wr_acc),
    .grp_o  (grp),
    .addr_o (addr),
    .last_o (last)
  );

`ifdef ZUMA_CFG_CHECKSUM_EN
  logic [NUM_LUTS-1:0] csum_q;
  logic                err_q;
  assign bus.cfg_error = err_q;
`else
  assign bus.cfg_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lut_a_q     <= '0;
      lut_d_q     <= '0;
      lut_we_q    <= '0;
`ifdef ZUMA_CFG_CHECKSUM_EN
      csum_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      lut_we_q <= '0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // done lands one cycle after the final strobe cycle
          if (state_q == ST_DONE) done_q <= 1'b1;
          if (bus.cfg_start) begin
            state_q     <= ST_LOAD;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef ZUMA_CFG_CHECKSUM_EN
            csum_q      <= '0;
            err_q       <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (wr_acc) begin
            lut_a_q  <= addr;
            lut_d_q  <= bus.cfg_data;
            lut_we_q <= we_onehot;
`ifdef ZUMA_CFG_CHECKSUM_EN
            csum_q   <= csum_q ^ bus.cfg_data;
            if (last) state_q <= ST_CHECK;
`else
            if (last) begin
              state_q     <= ST_DONE;
              cfg_ready_q <= 1'b0;
              busy_q      <= 1'b0;
            end
`endif
          end
        end
        ST_CHECK: begin
`ifdef ZUMA_CFG_CHECKSUM_EN
          if (bus.cfg_valid) begin
            err_q       <= (bus.cfg_data != csum_q);
            state_q     <= ST_DONE;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.lut_a     = lut_a_q;
  assign bus.lut_d     = lut_d_q;
  assign bus.lut_we    = lut_we_q;

endmodule

// File: tb/tb_zuma_lut_cfg_loader.sv
// Randomized bench for the LUT config loader; expected writes come from k -> (k/64, k%64).
module tb_zuma_lut_cfg_loader;

  localparam int LUT_K = 6;
  localparam int NL    = 8;
  localparam int NG    = 4;
  localparam int NDATA = NG * (1 << LUT_K);
`ifdef ZUMA_CFG_CHECKSUM_EN
  localparam int NW = NDATA + 1;
`else
  localparam int NW = NDATA;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zuma_lut_cfg_loader_if #(.LUT_K(LUT_K), .NUM_LUTS(NL), .NUM_GROUPS(NG)) bus ();

  zuma_lut_cfg_loader #(.LUT_K(LUT_K), .NUM_LUTS(NL), .NUM_GROUPS(NG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [NG-1:0]    cap_we[$];
  logic [LUT_K-1:0] cap_a[$];
  logic [NL-1:0]    cap_d[$];
  logic [NL-1:0]    words[0:NW-1];
  int cyc = 0;
  int last_strobe_cyc = 0;
  int done_rise_cyc = 0;
  int done_rises = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      done_prev = 1'b0;
    end else begin
      if (bus.lut_we != '0) begin
        cap_we.push_back(bus.lut_we);
        cap_a.push_back(bus.lut_a);
        cap_d.push_back(bus.lut_d);
        last_strobe_cyc = cyc;
      end
      if (bus.done && !done_prev) begin
        done_rises++;
        done_rise_cyc = cyc;
      end
      done_prev = bus.done;
    end
  end

  // pattern 0: data = word index; pattern 1: random data
  task automatic make_words(input int pattern, input bit bad_cs);
    logic [NL-1:0] x;
    x = '0;
    for (int k = 0; k < NDATA; k++) begin
      words[k] = (pattern == 0) ? NL'(k) : NL'($urandom);
      x ^= words[k];
    end
`ifdef ZUMA_CFG_CHECKSUM_EN
    words[NDATA] = x ^ NL'(bad_cs);
`else
    if (bad_cs && x == '1) words[0] = words[0];
`endif
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = cap_we.size();
    chk({tag, "_nstrobes"}, 32'(n), 32'(NDATA));
    if (n > NDATA) n = NDATA;
    for (int k = 0; k < n; k++) begin
      chk({tag, "_we"}, 32'(cap_we[k]), 32'(1 << (k / (1 << LUT_K))));
      chk({tag, "_a"},  32'(cap_a[k]),  32'(k % (1 << LUT_K)));
      chk({tag, "_d"},  32'(cap_d[k]),  32'(words[k]));
    end
  endtask

  // Runs one sequence; returns early (with reset asserted) when abort_at is reached.
  task automatic feed(input string tag, input int gap, input int dup_at, input int abort_at);
    int  k;
    int  budget;
    bit  acc;
    bit  dup_done;
    cap_we.delete(); cap_a.delete(); cap_d.delete();
    done_rises = 0;
    @(posedge clk); #1;
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    chk({tag, "_busy_start"},  32'(bus.busy), 32'd1);
    chk({tag, "_ready_start"}, 32'(bus.cfg_ready), 32'd1);
    chk({tag, "_done_clr"},    32'(bus.done), 32'd0);
    k = 0; budget = 0; dup_done = 1'b0;
    while (k < NW && budget < 4000) begin
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        break;
      end
      bus.cfg_valid = ($urandom_range(99) >= gap);
      bus.cfg_data  = words[k];
      bus.cfg_start = (k == dup_at) && !dup_done;
      if (bus.cfg_start) dup_done = 1'b1;
      acc = bus.cfg_valid && bus.cfg_ready;
      @(posedge clk); #1;
      if (acc) k++;
      budget++;
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_start = 1'b0;
    if (abort_at >= 0) return;
    chk({tag, "_words"}, 32'(k), 32'(NW));
    chk({tag, "_ready_drop"}, 32'(bus.cfg_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_rises"}, 32'(done_rises), 32'd1);
`ifndef ZUMA_CFG_CHECKSUM_EN
    chk({tag, "_done_lat"}, 32'(done_rise_cyc - last_strobe_cyc), 32'd1);
`endif
    check_writes(tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst_we",    32'(bus.lut_we), 32'd0);
    chk("rst_a",     32'(bus.lut_a), 32'd0);
    chk("rst_d",     32'(bus.lut_d), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_err",   32'(bus.cfg_error), 32'd0);
    reset = 1'b0;

    make_words(0, 1'b0);
    feed("full", 0, -1, -1);
    chk("full_err", 32'(bus.cfg_error), 32'd0);

    feed("gaps", 50, -1, -1);

    make_words(1, 1'b0);
    feed("dupstart", 20, 100, -1);

    feed("abort", 0, -1, 37);
    @(negedge clk);
    chk("abort_we",    32'(bus.lut_we), 32'd0);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_done",  32'(bus.done), 32'd0);
    chk("abort_ready", 32'(bus.cfg_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    make_words(1, 1'b0);
    feed("restart", 30, -1, -1);

    make_words(1, 1'b0);
    feed("b2b", 10, -1, -1);

`ifdef ZUMA_CFG_CHECKSUM_EN
    make_words(1, 1'b0);
    feed("cs_good", 25, -1, -1);
    chk("cs_good_err", 32'(bus.cfg_error), 32'd0);
    make_words(1, 1'b1);
    feed("cs_bad", 25, -1, -1);
    chk("cs_bad_err", 32'(bus.cfg_error), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zuma_lut_cfg_loader.md
# zuma_lut_cfg_loader

Configuration write engine that sits directly upstream of the overlay's LUTRAM wrappers. It accepts a stream of configuration words and turns each word into one LUTRAM write: address on `lut_a`, one data bit per LUT on `lut_d`, and a one-hot write-enable per LUT group on `lut_we`. It walks every address of every group exactly once per load sequence. When the sequence completes it flags `done`.

## Interface
Parameters:
- `LUT_K`, 6: LUT input count; depth per LUT is 2**LUT_K.
- `NUM_LUTS`, 8: LUTs written in parallel per group; also the width of `cfg_data` and `lut_d`.
- `NUM_GROUPS`, 4: number of LUT groups, each with its own write-enable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_start`  in  1  one-cycle pulse that begins a load sequence.
- `cfg_data`  in  NUM_LUTS  configuration word; bit i goes to LUT i of the current group.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  loader accepts a word this cycle.
- `lut_a`  out  LUT_K  LUTRAM write address.
- `lut_d`  out  NUM_LUTS  LUTRAM write data, one bit per LUT.
- `lut_we`  out  NUM_GROUPS  one-hot write strobe.
- `busy`  out  1  a load sequence is in progress.
- `done`  out  1  the last load sequence completed.
- `cfg_error`  out  1  checksum mismatch; only meaningful with the macro enabled.

## Operation
- States:
  - IDLE: `cfg_ready`=0.
  - LOAD: `cfg_ready`=1; counters are `grp` (0..NUM_GROUPS-1) and `addr` (0..2**LUT_K-1).
  - CHECK: present only with the macro.
  - DONE.
- Transitions:
  - IDLE → LOAD on `cfg_start`. Clears `grp`, `addr`, `done`, `cfg_error` and the checksum.
  - DONE → LOAD on `cfg_start`, with the same clearing as from IDLE.
  - `cfg_start` during LOAD or CHECK is ignored.
- Handshake: a word is accepted when `cfg_valid && cfg_ready`. `cfg_valid` low in LOAD stalls the sequence without any penalty.
- On acceptance:
  - Register `lut_a`=`addr`, `lut_d`=`cfg_data`, `lut_we`=1<<`grp`.
  - `addr` increments. When `addr` wraps to 0, `grp` increments.
- Final acceptance is `grp`=NUM_GROUPS-1 and `addr`=2**LUT_K-1. After it the loader goes to DONE, or to CHECK with the macro.
- Total words per sequence: NUM_GROUPS·2**LUT_K (256 at defaults), plus 1 with the macro.
- `busy` = state is LOAD or CHECK.
- DONE: `done`=1, held until the next `cfg_start` or `reset`.

## Timing
- Reset values:
  - State is IDLE.
  - `cfg_ready`, `lut_a`, `lut_d`, `lut_we`, `busy`, `done` and `cfg_error` are all 0.
- `cfg_start` at cycle n → `busy`=1 and `cfg_ready`=1 at n+1.
- Write latency: word accepted at cycle n → `lut_we` pulses high for exactly cycle n+1, with `lut_a`/`lut_d` valid in that same cycle.
- When no word was accepted in the previous cycle, `lut_we`=0. `lut_a` and `lut_d` hold their last values.
- `cfg_ready` drops in the cycle after the final acceptance, so no extra word is taken.
- `done` rises one cycle after the final write strobe cycle (the cycle after the final acceptance).
- Throughput is one write per cycle when `cfg_valid` is held high.
- `reset` asserted mid-sequence:
  - All outputs go to their reset values immediately.
  - Any pending strobe is dropped.
  - Partially written LUT contents are left as they are.

## Configuration
- Macro: `ZUMA_CFG_CHECKSUM_EN`.
- Defined:
  - The loader keeps a running XOR over all accepted data words.
  - After the final data word it enters CHECK with `cfg_ready`=1 and accepts one extra checksum word. That word produces no `lut_we`.
  - If the checksum word differs from the running XOR, `cfg_error`=1.
  - DONE follows the checksum word. `cfg_error` holds until the next `cfg_start` or `reset`.
- Undefined: no CHECK state, no checksum logic, `cfg_error` tied to 0.

## Structure
- Shared package `zuma_cfg_pkg`:
  - state enum (IDLE, LOAD, CHECK, DONE);
  - default constants `ZUMA_LUT_K`, `ZUMA_CFG_GROUPS`.
- One natural sub-module, `zuma_cfg_addr_counter`: the `grp`/`addr` counter pair, with a `last` flag and wrap logic.
- All other logic is flat in the top module.

## Test plan
- Full load at defaults, `cfg_valid` held high, data = address pattern → 256 strobes:
  - `lut_we` walks 0001→1000, with `lut_a` 0..63 in each group;
  - `done` high the cycle after the last strobe.
- Random `cfg_valid` gaps (50%) → exactly 256 strobes; order and data are identical to the gap-free run, no duplicates.
- `cfg_start` pulsed at word 100 of a sequence → ignored:
  - the sequence completes at 256 words;
  - `done` rises once.
- `reset` asserted at word 37 → next edge shows:
  - `lut_we`=0, `busy`=0, `done`=0;
  - a subsequent `cfg_start` restarts at `grp`=0, `addr`=0.
- Back-to-back sequences: `cfg_start` pulsed while in DONE → `done` cleared and a second full load proceeds normally.
- With `ZUMA_CFG_CHECKSUM_EN`:
  - correct XOR word → `cfg_error`=0;
  - XOR^8'h01 → `cfg_error`=1;
  - the checksum word produces no `lut_we`.
